// File: rtl/spdif_pkg.sv
// Shared constants and types for the SPDIF sample feeder.
// Bit-rate accumulator steps are 128 * fs in Hz.
package spdif_pkg;

    localparam int unsigned SAMPLE_W  = 32;
    localparam logic [31:0] STEP_44K1 = 32'd5644800;
    localparam logic [31:0] STEP_48K  = 32'd6144000;

    typedef enum logic {
        RATE_44K1 = 1'b0,
        RATE_48K  = 1'b1
    } rate_e;

    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic logic [31:0] rate_step(input rate_e rate);
        return (rate == RATE_48K) ? STEP_48K : STEP_44K1;
    endfunction

endpackage

// File: rtl/spdif_feeder_if.sv
// Upstream sample stream plus transmitter-side handshake of the SPDIF feeder.
// The feeder itself connects through the slave modport.
interface spdif_feeder_if;
    import spdif_pkg::*;

    logic    in_valid_i;
    sample_t in_sample_i;
    logic    in_ready_o;
    logic    sample_req_i;
    sample_t sample_o;
    logic    bit_en_o;

    modport master (
        output in_valid_i, in_sample_i, sample_req_i,
        input  in_ready_o, sample_o, bit_en_o
    );

    modport slave (
        input  in_valid_i, in_sample_i, sample_req_i,
        output in_ready_o, sample_o, bit_en_o
    );

endinterface

// File: rtl/spdif_sample_fifo.sv
// Power-of-two sample FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate occupancy counter.
module spdif_sample_fifo
    import spdif_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = SAMPLE_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_o  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset: clearing the pointers already discards it.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem[wr_ptr[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/spdif_feeder.sv
// SPDIF sample feeder: 128*fs bit-enable generator, sample FIFO and a
// single-word stage register handed to the transmitter on request.
module spdif_feeder
    import spdif_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 24576000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           rate_48k_i,
    spdif_feeder_if.slave  bus,
    output logic           underrun_o,
    output logic           overflow_o,
    output logic [7:0]     underrun_cnt_o
);

    localparam logic [31:0] CLK_W = 32'(CLK_HZ);

    rate_e       rate_q;
    rate_e       rate_prev;
    logic [31:0] acc;
    logic [31:0] acc_sum;
    logic        bit_en_q;

    sample_t     fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    sample_t     stage;
    logic        stage_v;
    logic        underrun_q;
    logic        overflow_q;
    logic [7:0]  underrun_cnt;

    assign acc_sum = acc + rate_step(rate_q);

    // A rate change restarts the accumulator from zero, suppressing bit_en that cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rate_q    <= RATE_44K1;
            rate_prev <= RATE_44K1;
            acc       <= '0;
            bit_en_q  <= 1'b0;
        end else begin
            rate_q    <= rate_e'(rate_48k_i);
            rate_prev <= rate_q;
            if (rate_q != rate_prev) begin
                acc      <= '0;
                bit_en_q <= 1'b0;
            end else if (acc_sum >= CLK_W) begin
                acc      <= acc_sum - CLK_W;
                bit_en_q <= 1'b1;
            end else begin
                acc      <= acc_sum;
                bit_en_q <= 1'b0;
            end
        end
    end

    // Push is judged on the pre-cycle full flag, so a same-cycle pop never rescues it.
    always_comb begin
        fifo_push = bus.in_valid_i && !fifo_full;
        fifo_pop  = !fifo_empty && (bus.sample_req_i || !stage_v);
    end

    spdif_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .din_i   (bus.in_sample_i),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage        <= '0;
            stage_v      <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            overflow_q <= bus.in_valid_i && fifo_full;
            underrun_q <= bus.sample_req_i && fifo_empty;
            if (fifo_pop) begin
                stage   <= fifo_head;
                stage_v <= 1'b1;
            end else if (bus.sample_req_i) begin
                stage   <= '0;
                stage_v <= 1'b0;
            end
            if (bus.sample_req_i && fifo_empty && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end

    assign bus.sample_o    = stage_v ? stage : '0;
    assign bus.in_ready_o  = !fifo_full;
    assign bus.bit_en_o    = bit_en_q;
    assign underrun_o      = underrun_q;
    assign overflow_o      = overflow_q;
    assign underrun_cnt_o  = underrun_cnt;

endmodule

// File: tb/tb_spdif_feeder.sv
// Directed bench for spdif_feeder: per-cycle vector table for the FIFO/stage
// path, hand sequences for bit-rate, saturation and reset corner cases.
module tb_spdif_feeder;
    import spdif_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rate_48k;
    logic       underrun;
    logic       overflow;
    logic [7:0] ucnt;

    int n_vec = 0;
    int n_bad = 0;

    spdif_feeder_if u_if ();

    spdif_feeder #(
        .CLK_HZ     (24576000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rate_48k_i     (rate_48k),
        .bus            (u_if),
        .underrun_o     (underrun),
        .overflow_o     (overflow),
        .underrun_cnt_o (ucnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        req;
        logic [31:0] exp_sample;
        logic        exp_ready;
        logic        exp_und;
        logic        exp_ovf;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                                input logic [31:0] s, input logic rdy, input logic u,
                                input logic o, input logic [7:0] c);
        vec_t t;
        t.valid = v; t.data = d; t.req = r;
        t.exp_sample = s; t.exp_ready = rdy; t.exp_und = u; t.exp_ovf = o; t.exp_cnt = c;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until the first bit_en pulse (0 if none within the budget); also flags non-mute output.
    task automatic first_bit_en(output int first, output int stale);
        first = 0;
        stale = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (u_if.sample_o !== 32'h0 || underrun !== 1'b0) stale++;
            if (u_if.bit_en_o === 1'b1 && first == 0) first = c;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, stale, pulses, last, bad_gap, n_und;

        vecs[0]  = mk(1, 32'h11112222, 0, 32'h00000000, 1, 0, 0, 8'd0);
        vecs[1]  = mk(1, 32'h33334444, 0, 32'h11112222, 1, 0, 0, 8'd0);
        vecs[2]  = mk(0, 32'h0,        1, 32'h33334444, 1, 0, 0, 8'd0);
        vecs[3]  = mk(0, 32'h0,        1, 32'h00000000, 1, 1, 0, 8'd1);
        vecs[4]  = mk(0, 32'h0,        0, 32'h00000000, 1, 0, 0, 8'd1);
        vecs[5]  = mk(1, 32'hA0000001, 0, 32'h00000000, 1, 0, 0, 8'd1);
        vecs[6]  = mk(1, 32'hA0000002, 0, 32'hA0000001, 1, 0, 0, 8'd1);
        vecs[7]  = mk(1, 32'hA0000003, 0, 32'hA0000001, 1, 0, 0, 8'd1);
        vecs[8]  = mk(1, 32'hA0000004, 0, 32'hA0000001, 1, 0, 0, 8'd1);
        vecs[9]  = mk(1, 32'hA0000005, 0, 32'hA0000001, 0, 0, 0, 8'd1);
        vecs[10] = mk(1, 32'hA0000006, 0, 32'hA0000001, 0, 0, 1, 8'd1);
        vecs[11] = mk(0, 32'h0,        0, 32'hA0000001, 0, 0, 0, 8'd1);
        vecs[12] = mk(1, 32'hA0000007, 1, 32'hA0000002, 1, 0, 1, 8'd1);
        vecs[13] = mk(0, 32'h0,        0, 32'hA0000002, 1, 0, 0, 8'd1);
        vecs[14] = mk(0, 32'h0,        1, 32'hA0000003, 1, 0, 0, 8'd1);
        vecs[15] = mk(0, 32'h0,        1, 32'hA0000004, 1, 0, 0, 8'd1);
        vecs[16] = mk(0, 32'h0,        1, 32'hA0000005, 1, 0, 0, 8'd1);
        vecs[17] = mk(1, 32'hA0000008, 1, 32'h00000000, 1, 1, 0, 8'd2);
        vecs[18] = mk(0, 32'h0,        0, 32'hA0000008, 1, 0, 0, 8'd2);
        vecs[19] = mk(0, 32'h0,        0, 32'hA0000008, 1, 0, 0, 8'd2);

        rst = 1'b1;
        rate_48k = 1'b0;
        u_if.in_valid_i = 1'b0;
        u_if.in_sample_i = '0;
        u_if.sample_req_i = 1'b0;
        repeat (3) step();
        check("rst_sample", u_if.sample_o, 32'h0);
        check("rst_ready", 32'(u_if.in_ready_o), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ucnt", 32'(ucnt), 32'd0);
        check("rst_bit_en", 32'(u_if.bit_en_o), 32'd0);

        rst = 1'b0;
        first_bit_en(first, stale);
        check("first_bit_en_after_rst", 32'(first), 32'd5);

        for (int i = 0; i < 20; i++) begin
            u_if.in_valid_i   = vecs[i].valid;
            u_if.in_sample_i  = vecs[i].data;
            u_if.sample_req_i = vecs[i].req;
            step();
            check($sformatf("v%0d_sample", i), u_if.sample_o, vecs[i].exp_sample);
            check($sformatf("v%0d_ready", i), 32'(u_if.in_ready_o), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_und));
            check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("v%0d_ucnt", i), 32'(ucnt), 32'(vecs[i].exp_cnt));
        end
        u_if.in_valid_i = 1'b0;

        // 300 requests against an empty FIFO: counter starts at 2 and saturates.
        n_und = 0;
        u_if.sample_req_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (underrun === 1'b1) n_und++;
        end
        u_if.sample_req_i = 1'b0;
        check("sat_underrun_pulses", 32'(n_und), 32'd300);
        check("sat_ucnt", 32'(ucnt), 32'd255);
        check("sat_sample_mute", u_if.sample_o, 32'h0);
        step();
        check("sat_underrun_idle", 32'(underrun), 32'd0);
        check("sat_ucnt_hold", 32'(ucnt), 32'd255);

        // 48 kHz: register the new rate, clear edge, then a pulse every 4th cycle.
        rate_48k = 1'b1;
        step();
        step();
        check("r48_clear_bit_en", 32'(u_if.bit_en_o), 32'd0);
        pulses = 0; last = 0; bad_gap = 0; first = 0;
        for (int c = 1; c <= 24576; c++) begin
            step();
            if (u_if.bit_en_o === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
                else if (c - last != 4) bad_gap++;
                last = c;
            end
        end
        check("r48_first_pulse", 32'(first), 32'd4);
        check("r48_pulses", 32'(pulses), 32'd6144);
        check("r48_gaps", 32'(bad_gap), 32'd0);

        // 44.1 kHz: pattern repeats every 640 cycles with 147 pulses.
        rate_48k = 1'b0;
        step();
        step();
        check("r44_clear_bit_en", 32'(u_if.bit_en_o), 32'd0);
        pulses = 0; last = 0; bad_gap = 0; first = 0;
        for (int c = 1; c <= 1280; c++) begin
            step();
            if (u_if.bit_en_o === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
                else if (c - last != 4 && c - last != 5) bad_gap++;
                last = c;
            end
        end
        check("r44_first_pulse", 32'(first), 32'd5);
        check("r44_pulses", 32'(pulses), 32'd294);
        check("r44_gaps", 32'(bad_gap), 32'd0);

        // Rate toggle with words queued, then a one-cycle reset.
        rate_48k = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_if.in_valid_i  = 1'b1;
            u_if.in_sample_i = 32'hB0000000 + 32'(i);
            step();
        end
        u_if.in_valid_i = 1'b0;
        step();
        check("pre_rst_sample", u_if.sample_o, 32'hB0000000);
        rate_48k = 1'b0;
        rst = 1'b1;
        #2;
        check("mid_rst_sample", u_if.sample_o, 32'h0);
        check("mid_rst_ready", 32'(u_if.in_ready_o), 32'd1);
        check("mid_rst_ucnt", 32'(ucnt), 32'd0);
        check("mid_rst_bit_en", 32'(u_if.bit_en_o), 32'd0);
        step();
        rst = 1'b0;
        first_bit_en(first, stale);
        check("post_rst_first_bit_en", 32'(first), 32'd5);
        check("post_rst_no_stale", 32'(stale), 32'd0);
        check("post_rst_ready", 32'(u_if.in_ready_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spdif_feeder.md
SPDIF_FEEDER -- requirements
Module: spdif_feeder

Interface
REQ-001 Parameter CLK_HZ, default 24576000, clk_i frequency in Hz; legal range 12288000..200000000.
REQ-002 Parameter FIFO_DEPTH, default 4, sample FIFO entries; power of two, 2..16.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 rate_48k_i  input  1  sample-rate select: 1 = 48 kHz, 0 = 44.1 kHz.
REQ-006 in_valid_i  input  1  upstream sample strobe.
REQ-007 in_sample_i  input  32  upstream stereo word: [15:0] left, [31:16] right.
REQ-008 in_ready_o  output  1  high when the FIFO is not full.
REQ-009 bit_en_o  output  1  single-cycle pulse at 128*fs, driving the SPDIF transmitter bit rate.
REQ-010 sample_o  output  32  staged stereo word presented to the transmitter.
REQ-011 sample_req_i  input  1  transmitter pulse meaning "staged word consumed, stage the next one".
REQ-012 underrun_o  output  1  single-cycle pulse when sample_req_i finds no data available.
REQ-013 overflow_o  output  1  single-cycle pulse when in_valid_i is dropped because the FIFO is full.
REQ-014 underrun_cnt_o  output  8  saturating count of underruns.

Function
REQ-015 Bit-rate generator: 32-bit phase accumulator; STEP = 5644800 when rate_48k_i=0, 6144000 when 1.
REQ-016 Each cycle: if acc+STEP >= CLK_HZ then acc <= acc+STEP-CLK_HZ and bit_en_o=1 (registered), else acc <= acc+STEP and bit_en_o=0.
REQ-017 bit_en_o is never high on two consecutive cycles (guaranteed by CLK_HZ >= 2*STEP).
REQ-018 rate_48k_i is registered once; a change of the registered value clears acc to 0 on the following cycle, and bit_en_o=0 on that cycle.
REQ-019 FIFO write: in_valid_i && in_ready_o pushes in_sample_i; in_valid_i && !in_ready_o drops the word and pulses overflow_o on the next cycle.
REQ-020 in_ready_o = !full, registered-state derived (no combinational path from sample_req_i).
REQ-021 Stage register: holds word plus stage_v flag; when stage_v=0 and FIFO non-empty, pop head into stage and set stage_v=1 (one-cycle latency).
REQ-022 On sample_req_i with FIFO non-empty: stage <= head, pop, stage_v=1, all in the same cycle.
REQ-023 On sample_req_i with FIFO empty: stage <= 32'h0, stage_v=0, underrun_o pulses next cycle, underrun_cnt_o increments and saturates at 255.
REQ-024 sample_o = stage word when stage_v=1, else 32'h0 (mute); it changes only on the cycle after a req or refill.
REQ-025 Simultaneous push and pop on a full FIFO: the pop frees an entry but the push is still evaluated against the pre-cycle full flag (dropped, overflow_o pulses).
REQ-026 Simultaneous push and pop on an empty FIFO with sample_req_i: the word is not bypassed; underrun occurs and the word is written to the FIFO.
REQ-027 Pointer wrap: read and write pointers are log2(FIFO_DEPTH)+1 bits; full and empty are decoded from MSB/LSB comparison.

Reset
REQ-028 rst_i clears acc, pointers, stage, stage_v and counters; bit_en_o=0, sample_o=0, in_ready_o=1, underrun_o=0, overflow_o=0, underrun_cnt_o=0.
REQ-029 Reset mid-operation discards all FIFO contents; the first bit_en_o after release occurs no earlier than ceil(CLK_HZ/STEP) cycles.

Structure
REQ-030 Shared package spdif_pkg holds the STEP constants (5644800, 6144000) and the sample word width (32).
REQ-031 One sub-module, spdif_sample_fifo (parameterised FIFO with push/pop/full/empty), is instantiated once; the accumulator and stage logic are in the top level.

Verification
REQ-032 CLK_HZ=24576000, rate_48k_i=1 -> bit_en_o exactly every 4th cycle; 6144 pulses in 24576 cycles.
REQ-033 CLK_HZ=24576000, rate_48k_i=0 -> 5644800 pulses per 24576000 cycles (checked over 24576000 cycles); pulse spacing is always 4 or 5 cycles.
REQ-034 Push 0x11112222, 0x33334444; pulse sample_req_i twice -> sample_o shows 0x11112222, then 0x33334444, then 0x00000000 with one underrun_o pulse and underrun_cnt_o=1.
REQ-035 FIFO_DEPTH=4, no req, push 6 words -> after priming, stage holds word 1, FIFO holds words 2-5, in_ready_o=0, word 6 dropped, overflow_o pulses once.
REQ-036 300 sample_req_i pulses with FIFO empty -> underrun_cnt_o=255 (saturated).
REQ-037 Toggle rate_48k_i mid-stream, then assert rst_i for 1 cycle with 3 words queued -> acc cleared, sample_o=0, in_ready_o=1, no stale word is emitted after release.
